// File: rtl/aes_round_engine.sv
// Iterative AES-128/192/256 encryption core, one round per clock, valid/ready on both sides.
// Define AES_OUT_BUF_EN to add a one-entry output buffer that lets the next block start early.
module aes_round_engine #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [127:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic [3:0]       rk_idx,
    output logic [1:0]       rk_mode,
    input  logic [127:0]     round_key,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Byte i of the 128-bit state sits at bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = SBOX[s[127-8*i -: 8]];
        return r;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++)
                r[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
        return r;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return r;
    endfunction

    function automatic logic [127:0] add_round_key(input logic [127:0] s, input logic [127:0] k);
        return s ^ k;
    endfunction

`ifdef AES_OUT_BUF_EN
    typedef enum logic [1:0] {IDLE, RUN} fsm_e;
`else
    typedef enum logic [1:0] {IDLE, RUN, HOLD} fsm_e;
`endif

    fsm_e             fsm_q;
    logic [3:0]       rnd_q;
    logic [127:0]     st_q;
    logic [1:0]       mode_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]       nr;
    logic             last_round;
    logic [127:0]     sb_sr;
    logic [127:0]     round_out;

    // Mode 11 deliberately falls into the AES-256 branch.
    assign nr         = (mode_q == 2'b00) ? 4'd10 : (mode_q == 2'b01) ? 4'd12 : 4'd14;
    assign last_round = (rnd_q == nr);
    assign sb_sr      = shift_rows(sub_bytes(st_q));
    assign round_out  = add_round_key(last_round ? sb_sr : mix_columns(sb_sr), round_key);

    assign in_ready = (fsm_q == IDLE) && !reset;
    assign busy     = (fsm_q == RUN);
    assign rk_idx   = (fsm_q == IDLE) ? 4'd0 : rnd_q;
    assign rk_mode  = (fsm_q == IDLE) ? in_mode : mode_q;

`ifdef AES_OUT_BUF_EN
    logic             ob_valid_q;
    logic [127:0]     ob_data_q;
    logic [TAG_W-1:0] ob_tag_q;

    assign out_valid = ob_valid_q;
    assign out_data  = ob_data_q;
    assign out_tag   = ob_tag_q;
`else
    assign out_valid = (fsm_q == HOLD);
    assign out_data  = st_q;
    assign out_tag   = tag_q;
`endif

    // NOTE: nonblocking assignments only; round_out must see the pre-edge state and counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q  <= IDLE;
            rnd_q  <= '0;
            st_q   <= '0;
            mode_q <= '0;
            tag_q  <= '0;
`ifdef AES_OUT_BUF_EN
            ob_valid_q <= 1'b0;
            ob_data_q  <= '0;
            ob_tag_q   <= '0;
`endif
        end else begin
`ifdef AES_OUT_BUF_EN
            if (ob_valid_q && out_ready) ob_valid_q <= 1'b0;
`endif
            case (fsm_q)
                IDLE: begin
                    if (in_valid) begin
                        st_q   <= in_data ^ round_key;
                        mode_q <= in_mode;
                        tag_q  <= in_tag;
                        rnd_q  <= 4'd1;
                        fsm_q  <= RUN;
                    end
                end
                RUN: begin
                    if (!last_round) begin
                        st_q  <= round_out;
                        rnd_q <= rnd_q + 4'd1;
                    end else begin
`ifdef AES_OUT_BUF_EN
                        // Stall with rk_idx parked at Nr until the buffer has room.
                        if (!ob_valid_q || out_ready) begin
                            ob_valid_q <= 1'b1;
                            ob_data_q  <= round_out;
                            ob_tag_q   <= tag_q;
                            rnd_q      <= '0;
                            fsm_q      <= IDLE;
                        end
`else
                        st_q  <= round_out;
                        fsm_q <= HOLD;
`endif
                    end
                end
`ifndef AES_OUT_BUF_EN
                HOLD: begin
                    if (out_ready) begin
                        rnd_q <= '0;
                        fsm_q <= IDLE;
                    end
                end
`endif
                default: fsm_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: key-schedule model driven by rk_idx/rk_mode,
// scoreboard of expected ciphertexts, directed FIPS-197 vectors; honours AES_OUT_BUF_EN.
module tb_aes_round_engine;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
`ifdef AES_OUT_BUF_EN
    localparam int SPACING = 11;
`else
    localparam int SPACING = 12;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_mode;
    logic [127:0] in_data;
    logic [3:0]   in_tag;
    logic [3:0]   rk_idx;
    logic [1:0]   rk_mode;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_tag;
    logic         busy;

    aes_round_engine #(.TAG_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_data(in_data), .in_tag(in_tag),
        .rk_idx(rk_idx), .rk_mode(rk_mode), .round_key(round_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int last_acc = 0;
    int prev_acc = 0;
    int exp_acc = 0;
    bit shown = 1'b0;

    typedef struct {
        logic [127:0] data;
        logic [3:0]   tag;
        int           acc_cyc;
        int           nr;
        bit           chk_lat;
    } exp_t;
    exp_t sb[$];

    logic [127:0] cur_data;
    logic [3:0]   cur_tag;
    int           cur_nr;
    bit           cur_chk;

    // Key-schedule model: expanded round keys per mode, served combinationally.
    logic [7:0]   sbox_m [256];
    logic [127:0] rk_tab [3][16];
    logic [1:0]   msel;
    assign msel      = (rk_mode == 2'b00) ? 2'd0 : (rk_mode == 2'b01) ? 2'd1 : 2'd2;
    assign round_key = rk_tab[msel][rk_idx];

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] b, inv;
        for (int v = 0; v < 256; v++) begin
            b   = 8'(v);
            inv = 8'h01;
            for (int k = 0; k < 254; k++) inv = gmul(inv, b);
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
    endfunction

    task automatic expand(input int nk, input int nr, input int m);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < nk; i++) w[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
        rc = 8'h01;
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) rk_tab[m][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor and acceptance recorder, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    check("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    if (!shown && sb[0].chk_lat)
                        check("latency", 128'(cyc - sb[0].acc_cyc), 128'(sb[0].nr + 1));
                    check("out_data", out_data, sb[0].data);
                    check("out_tag", 128'(out_tag), 128'(sb[0].tag));
                    if (out_ready) begin
                        sb.delete(0);
                        shown <= 1'b0;
                    end else begin
                        shown <= 1'b1;
                    end
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{cur_data, cur_tag, cyc, cur_nr, cur_chk});
                prev_acc <= last_acc;
                last_acc <= cyc;
                acc_cnt  <= acc_cnt + 1;
            end
        end
    end

    task automatic send(input logic [1:0] mode, input logic [3:0] tag, input logic [127:0] exp_ct,
                        input int nr, input bit chk_lat);
        cur_data = exp_ct;
        cur_tag  = tag;
        cur_nr   = nr;
        cur_chk  = chk_lat;
        in_mode  = mode;
        in_data  = PT;
        in_tag   = tag;
        in_valid = 1'b1;
        exp_acc++;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (acc_cnt < exp_acc && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("accepted", 128'(acc_cnt >= exp_acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained", 128'(sb.size()), 128'(0));
    endtask

    initial begin
        int n;
        reset = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_data = '0; in_tag = '0; out_ready = 1'b1;
        cur_data = '0; cur_tag = '0; cur_nr = 10; cur_chk = 1'b0;
        build_sbox();
        expand(4, 10, 0);
        expand(6, 12, 1);
        expand(8, 14, 2);

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 128'(in_ready), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", out_data, 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        reset = 1'b0;
        #1;
        check("ready_after_reset", 128'(in_ready), 128'(1));

        // Single blocks in each mode.
        send(2'b00, 4'h3, C128, 10, 1'b1);
        wait_accept();
        check("run_busy", 128'(busy), 128'(1));
        check("run_in_ready", 128'(in_ready), 128'(0));
        check("run_rk_idx", 128'(rk_idx), 128'(1));
        check("run_rk_mode", 128'(rk_mode), 128'(0));
        wait_drain();
        send(2'b01, 4'ha, C192, 12, 1'b1);
        wait_accept();
        wait_drain();
        send(2'b10, 4'hc, C256, 14, 1'b1);
        wait_accept();
        wait_drain();

        // Backpressure: first result held 20 cycles while a second block is offered.
        out_ready = 1'b0;
        send(2'b00, 4'h9, C128, 10, 1'b1);
        wait_accept();
        send(2'b01, 4'hb, C192, 12, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_out_valid", 128'(out_valid), 128'(1));
        repeat (20) begin
            @(posedge clk); #1;
`ifndef AES_OUT_BUF_EN
            check("bp_in_ready_low", 128'(in_ready), 128'(0));
`endif
        end
`ifdef AES_OUT_BUF_EN
        check("bp_stall_rk_idx", 128'(rk_idx), 128'(12));
        check("bp_stall_busy", 128'(busy), 128'(1));
`endif
        check("bp_still_valid", 128'(out_valid), 128'(1));
        out_ready = 1'b1;
        wait_accept();
        wait_drain();

        // Reset in round 5 of an AES-256 block discards it.
        send(2'b10, 4'h5, C256, 14, 1'b1);
        wait_accept();
        n = 0;
        while (rk_idx != 4'd5 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("rst_mid_round5", 128'(rk_idx), 128'(5));
        reset = 1'b1;
        #1;
        check("rst_mid_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_out_valid", 128'(out_valid), 128'(0));
        check("rst_mid_in_ready", 128'(in_ready), 128'(1));
        check("rst_mid_busy", 128'(busy), 128'(0));
        check("rst_mid_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_mid_out_tag", 128'(out_tag), 128'(0));
        send(2'b11, 4'h6, C256, 14, 1'b1);
        wait_accept();
        wait_drain();

        // in_mode toggled every cycle while an AES-192 block runs.
        send(2'b01, 4'h7, C192, 12, 1'b1);
        wait_accept();
        n = 0;
        while (busy && n < 30) begin
            check("toggle_rk_mode", 128'(rk_mode), 128'(1));
            in_mode = in_mode + 2'd1;
            @(posedge clk); #1;
            n++;
        end
        check("toggle_done", 128'(busy), 128'(0));
        in_mode = 2'b00;
        wait_drain();

        // Back-to-back AES-128 blocks, tags 0..7.
        for (int k = 0; k < 8; k++) begin
            send(2'b00, 4'(k), C128, 10, 1'b1);
            wait_accept();
            if (k > 0) check("b2b_spacing", 128'(last_acc - prev_acc), 128'(SPACING));
        end
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
